// File: rtl/rc4_stream_engine.sv
// rc4_stream_engine
//   RC4 stream cipher engine (encrypt and decrypt are the same XOR). Loads a
//   KEY_LEN-byte key, runs the key schedule, optionally discards DROP_N
//   keystream bytes, then prefetches keystream into a small FIFO and XORs it
//   onto the byte stream presented at the input port.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-low reset
//   key_start  one-cycle pulse: abort everything, flush, start key load
//   key_valid  key_data holds the next key byte (byte 0 first)
//   key_data   key byte
//   init_done  high while in RUN
//   busy       high in LOAD, INIT, KSA, DROP
//   in_valid / in_ready / in_data     input byte stream
//   out_valid / out_ready / out_data  XOR result stream
//   state_dbg  current FSM state encoding (debug visibility)
//
// Handshake: a byte moves on a rising edge where valid && ready are both
// high. A producer holds valid and data stable until the byte moves; ready
// may change freely. out_valid/out_data are registered.

module rc4_stream_engine #(
  parameter int KEY_LEN    = 3,
  parameter int DROP_N     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       init_done,
  output logic       busy,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INIT = 3'd2,
    ST_KSA  = 3'd3,
    ST_DROP = 3'd4,
    ST_RUN  = 3'd5
  } state_t;

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  K_LAST    = 5'(KEY_LEN - 1);
  localparam logic [11:0] DROP_LAST = 12'((DROP_N > 0) ? DROP_N - 1 : 0);

  state_t state, state_d;

  logic [7:0]  s_mem   [256];
  logic [7:0]  key_mem [32];   // only entries 0..KEY_LEN-1 are used
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [7:0]  i, j;
  logic [4:0]  k;              // key load index, then key index during KSA
  logic [11:0] drop_cnt;
  logic [AW:0] wr_ptr, rd_ptr;

  // KSA datapath
  logic [7:0] s_i, j_ksa, s_jksa;
  // PRGA datapath
  logic [7:0] i1, si, j1, sj, t, ks_byte;
  // shared swap port
  logic [7:0] sw_a, sw_b, val_a, val_b;

  logic fifo_empty, fifo_full;
  logic ksa_step, prga_step, push, pop;
  logic [7:0] fifo_head;

  assign s_i    = s_mem[i];
  assign j_ksa  = j + s_i + key_mem[k];
  assign s_jksa = s_mem[j_ksa];

  assign i1 = i + 8'd1;
  assign si = s_mem[i1];
  assign j1 = j + si;
  assign sj = s_mem[j1];
  assign t  = si + sj;
  // Keystream byte is S[t] after the swap; the two swapped slots are
  // forwarded so the read does not depend on the write landing first.
  // When i1 == j1 the swap is a no-op and si == sj, so either path is right.
  assign ks_byte = (t == i1) ? sj : ((t == j1) ? si : s_mem[t]);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

  assign in_ready  = (state == ST_RUN) && !fifo_empty && (!out_valid || out_ready);
  assign pop       = in_valid && in_ready && !key_start;
  assign ksa_step  = (state == ST_KSA) && !key_start;
  // Full FIFO stalls generation unless a slot frees up this same cycle.
  assign prga_step = !key_start &&
                     ((state == ST_DROP) || ((state == ST_RUN) && (!fifo_full || pop)));
  assign push      = prga_step && (state == ST_RUN);

  assign sw_a  = (state == ST_KSA) ? i      : i1;
  assign sw_b  = (state == ST_KSA) ? j_ksa  : j1;
  assign val_a = (state == ST_KSA) ? s_i    : si;
  assign val_b = (state == ST_KSA) ? s_jksa : sj;

  assign init_done = (state == ST_RUN);
  assign busy      = (state == ST_LOAD) || (state == ST_INIT) ||
                     (state == ST_KSA)  || (state == ST_DROP);
  assign state_dbg = state;

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_LOAD: if (key_valid && (k == K_LAST)) state_d = ST_INIT;
      ST_INIT: state_d = ST_KSA;
      ST_KSA:  if (i == 8'hFF) state_d = (DROP_N == 0) ? ST_RUN : ST_DROP;
      ST_DROP: if (drop_cnt == DROP_LAST) state_d = ST_RUN;
      default: state_d = state;
    endcase
    if (key_start) state_d = ST_LOAD;
  end

  // Control state, indices, FIFO pointers, output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= 5'd0;
      drop_cnt  <= 12'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
    end else begin
      state <= state_d;
      if (key_start) begin
        k         <= 5'd0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: if (key_valid) k <= k + 5'd1;
          ST_INIT: begin
            i <= 8'd0;
            j <= 8'd0;
            k <= 5'd0;
          end
          ST_KSA: begin
            i        <= i + 8'd1;
            j        <= (i == 8'hFF) ? 8'd0 : j_ksa;
            k        <= (k == K_LAST) ? 5'd0 : k + 5'd1;
            drop_cnt <= 12'd0;
          end
          ST_DROP: drop_cnt <= drop_cnt + 12'd1;
          default: ;
        endcase
        if (prga_step) begin
          i <= i1;
          j <= j1;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr    <= rd_ptr + 1'b1;
          out_valid <= 1'b1;
          out_data  <= in_data ^ fifo_head;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // Permutation state: contents are meaningless until INIT, so no reset.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      for (int n = 0; n < 256; n++) s_mem[n] <= 8'(n);
    end else if (ksa_step || prga_step) begin
      s_mem[sw_a] <= val_b;
      s_mem[sw_b] <= val_a;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_LOAD) && key_valid && !key_start) key_mem[k] <= key_data;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= ks_byte;
  end

endmodule

// File: tb/tb_rc4_stream_engine.sv
// Directed bench for rc4_stream_engine. Four instances:
//   0: KEY_LEN=3, DROP_N=0  ("Key" vectors, backpressure, abort, reset)
//   1: KEY_LEN=4            ("Wiki" encrypt)
//   2: KEY_LEN=4            ("Wiki" decrypt of instance 1 output)
//   3: KEY_LEN=3, DROP_N=2, FIFO_DEPTH=2
module tb_rc4_stream_engine;

  logic clk;
  logic rst;
  logic       key_start [4];
  logic       key_valid [4];
  logic [7:0] key_data  [4];
  logic       init_done [4];
  logic       busy      [4];
  logic       in_valid  [4];
  logic       in_ready  [4];
  logic [7:0] in_data   [4];
  logic       out_valid [4];
  logic       out_ready [4];
  logic [7:0] out_data  [4];
  logic [2:0] state_dbg [4];

  int checks = 0;
  int errors = 0;

  logic [7:0] key_buf [8];
  int         key_len;
  logic [7:0] pt_buf  [16];
  logic [7:0] got_buf [16];
  logic [7:0] exp_q [$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  rc4_stream_engine #(.KEY_LEN(3), .DROP_N(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst),
    .key_start(key_start[0]), .key_valid(key_valid[0]), .key_data(key_data[0]),
    .init_done(init_done[0]), .busy(busy[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .state_dbg(state_dbg[0]));

  rc4_stream_engine #(.KEY_LEN(4), .DROP_N(0), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst),
    .key_start(key_start[1]), .key_valid(key_valid[1]), .key_data(key_data[1]),
    .init_done(init_done[1]), .busy(busy[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .state_dbg(state_dbg[1]));

  rc4_stream_engine #(.KEY_LEN(4), .DROP_N(0), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst),
    .key_start(key_start[2]), .key_valid(key_valid[2]), .key_data(key_data[2]),
    .init_done(init_done[2]), .busy(busy[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .state_dbg(state_dbg[2]));

  rc4_stream_engine #(.KEY_LEN(3), .DROP_N(2), .FIFO_DEPTH(2)) dut3 (
    .clk(clk), .rst(rst),
    .key_start(key_start[3]), .key_valid(key_valid[3]), .key_data(key_data[3]),
    .init_done(init_done[3]), .busy(busy[3]),
    .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
    .state_dbg(state_dbg[3]));

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key_key();
    key_len = 3;
    key_buf[0] = 8'h4B; key_buf[1] = 8'h65; key_buf[2] = 8'h79;
  endtask

  task automatic set_key_wiki();
    key_len = 4;
    key_buf[0] = 8'h57; key_buf[1] = 8'h69; key_buf[2] = 8'h6B; key_buf[3] = 8'h69;
  endtask

  task automatic set_pt_plaintext();
    pt_buf[0] = 8'h50; pt_buf[1] = 8'h6C; pt_buf[2] = 8'h61;
    pt_buf[3] = 8'h69; pt_buf[4] = 8'h6E; pt_buf[5] = 8'h74;
    pt_buf[6] = 8'h65; pt_buf[7] = 8'h78; pt_buf[8] = 8'h74;
  endtask

  // "Plaintext" under key "Key"
  task automatic push_exp_key_ct(input int n);
    logic [7:0] ct [9];
    ct[0] = 8'hBB; ct[1] = 8'hF3; ct[2] = 8'h16; ct[3] = 8'hE8; ct[4] = 8'hD9;
    ct[5] = 8'h40; ct[6] = 8'hAF; ct[7] = 8'h0A; ct[8] = 8'hD3;
    exp_q.delete();
    for (int b = 0; b < n; b++) exp_q.push_back(ct[b]);
  endtask

  // Pulse key_start (with a competing junk key byte and input byte that
  // must be ignored), then deliver key_buf, optionally with gap cycles.
  task automatic load_bytes(input int idx, input bit gap);
    key_start[idx] = 1'b1;
    key_valid[idx] = 1'b1;
    key_data[idx]  = 8'hFF;
    in_valid[idx]  = 1'b1;
    in_data[idx]   = 8'h00;
    tick();
    key_start[idx] = 1'b0;
    in_valid[idx]  = 1'b0;
    check("load_state", state_dbg[idx], 3'd1);
    for (int b = 0; b < key_len; b++) begin
      key_valid[idx] = 1'b1;
      key_data[idx]  = key_buf[b];
      tick();
      if (gap && (b != key_len - 1)) begin
        key_valid[idx] = 1'b0;
        tick();
      end
    end
    key_valid[idx] = 1'b0;
  endtask

  // exp_cyc: cycle of RUN entry counted from the last key byte's cycle.
  task automatic load_key(input int idx, input bit gap, input int exp_cyc);
    int n;
    load_bytes(idx, gap);
    n = 0;
    while ((init_done[idx] !== 1'b1) && (n < 5000)) begin
      tick();
      n++;
    end
    check("init_cycles", n + 1, exp_cyc);
    check("busy_at_run", busy[idx], 1'b0);
    check("ready_at_run", in_ready[idx], 1'b0);
    tick();
    check("ready_after_run", in_ready[idx], 1'b1);
  endtask

  // Offer n_in bytes of pt_buf and collect n_out outputs, scoring each
  // against exp_q. bp: random in_valid gaps and out_ready pattern 1,0,0,1.
  task automatic stream(input int idx, input int n_in, input int n_out, input bit bp);
    int sent, got, cyc;
    logic [7:0] exp_v;
    logic [3:0] rdy_pat;
    rdy_pat = 4'b1001;
    sent = 0; got = 0; cyc = 0;
    while ((got < n_out) && (cyc < 300)) begin
      in_valid[idx]  = (sent < n_in) && (!bp || ($urandom_range(0, 1) == 1));
      in_data[idx]   = (sent < n_in) ? pt_buf[sent] : 8'h00;
      out_ready[idx] = bp ? rdy_pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (in_valid[idx] && in_ready[idx]) sent++;
      if (out_valid[idx] && out_ready[idx]) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("out_data", out_data[idx], exp_v);
        got_buf[got] = out_data[idx];
        got++;
      end
      tick();
      cyc++;
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b0;
    check("stream_count", got, n_out);
    check("exp_q_left", exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    for (int d = 0; d < 4; d++) begin
      key_start[d] = 1'b0; key_valid[d] = 1'b0; key_data[d] = 8'h00;
      in_valid[d]  = 1'b0; in_data[d]   = 8'h00; out_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    // reset values
    check("rst_out_valid", out_valid[0], 1'b0);
    check("rst_out_data",  out_data[0],  8'h00);
    check("rst_init_done", init_done[0], 1'b0);
    check("rst_busy",      busy[0],      1'b0);
    check("rst_in_ready",  in_ready[0],  1'b0);
    check("rst_state",     state_dbg[0], 3'd0);
    rst = 1'b1;
    tick();
    check("idle_busy", busy[0], 1'b0);

    // 1: "Key" / "Plaintext" full rate, RUN 258 cycles after last key byte
    set_key_key();
    set_pt_plaintext();
    load_key(0, 1'b0, 258);
    push_exp_key_ct(9);
    stream(0, 9, 9, 1'b0);

    // 2: "Wiki" / "pedia", then decrypt on a second instance
    set_key_wiki();
    load_key(1, 1'b1, 258);
    pt_buf[0] = 8'h70; pt_buf[1] = 8'h65; pt_buf[2] = 8'h64; pt_buf[3] = 8'h69; pt_buf[4] = 8'h61;
    exp_q.delete();
    exp_q.push_back(8'h10); exp_q.push_back(8'h21); exp_q.push_back(8'hBF);
    exp_q.push_back(8'h04); exp_q.push_back(8'h20);
    stream(1, 5, 5, 1'b0);
    load_key(2, 1'b0, 258);
    for (int b = 0; b < 5; b++) pt_buf[b] = got_buf[b];
    exp_q.delete();
    exp_q.push_back(8'h70); exp_q.push_back(8'h65); exp_q.push_back(8'h64);
    exp_q.push_back(8'h69); exp_q.push_back(8'h61);
    stream(2, 5, 5, 1'b0);

    // 3: backpressure on the "Key" vector
    set_key_key();
    set_pt_plaintext();
    load_key(0, 1'b1, 258);
    push_exp_key_ct(9);
    stream(0, 9, 9, 1'b1);

    // 4: RC4-drop[2]: first keystream byte seen is 77, then 81
    load_key(3, 1'b0, 260);
    pt_buf[0] = 8'h00; pt_buf[1] = 8'h01;
    exp_q.delete();
    exp_q.push_back(8'h77); exp_q.push_back(8'h80);
    stream(3, 2, 2, 1'b0);

    // 5: abort mid-stream after 4 outputs, with a 5th result pending
    set_pt_plaintext();
    load_key(0, 1'b0, 258);
    push_exp_key_ct(4);
    stream(0, 5, 4, 1'b0);
    check("pending_before_abort", out_valid[0], 1'b1);
    key_start[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'h55;
    out_ready[0] = 1'b1;
    tick();
    key_start[0] = 1'b0;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("abort_out_valid", out_valid[0], 1'b0);
    check("abort_in_ready",  in_ready[0],  1'b0);
    check("abort_state",     state_dbg[0], 3'd1);
    check("abort_init_done", init_done[0], 1'b0);
    load_key(0, 1'b0, 258);
    push_exp_key_ct(9);
    stream(0, 9, 9, 1'b0);

    // 6: asynchronous reset in the middle of KSA
    load_bytes(0, 1'b0);
    repeat (100) tick();
    check("mid_ksa_state", state_dbg[0], 3'd3);
    check("mid_ksa_busy",  busy[0],      1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid[0], 1'b0);
    check("arst_out_data",  out_data[0],  8'h00);
    check("arst_init_done", init_done[0], 1'b0);
    check("arst_busy",      busy[0],      1'b0);
    check("arst_in_ready",  in_ready[0],  1'b0);
    check("arst_state",     state_dbg[0], 3'd0);
    #3 rst = 1'b1;
    tick();
    load_key(0, 1'b0, 258);
    push_exp_key_ct(9);
    stream(0, 9, 9, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
